// File: rtl/shift_out_ctrl_if.sv
// Parallel-load / serial-out handshake bundle for shift_out_ctrl.
// master drives the request side, slave (the controller) drives the serial side.
interface shift_out_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             lsb_first;
  logic             sclk;
  logic             sdata;
  logic             latch;
  logic             busy;
  logic             done;

  modport master (
    output start, data_in, lsb_first,
    input  sclk, sdata, latch, busy, done
  );

  modport slave (
    input  start, data_in, lsb_first,
    output sclk, sdata, latch, busy, done
  );
endinterface

// File: rtl/shift_out_ctrl.sv
// Serialises a WIDTH-bit word onto sclk/sdata, then strobes latch for one phase.
// Every sclk phase lasts DIVVAL+1 clk_in cycles; all outputs are registered.
module shift_out_ctrl #(
  parameter int WIDTH  = 8,
  parameter int DIVVAL = 10
) (
  input  logic            clk_in,
  input  logic            reset,
  shift_out_ctrl_if.slave bus
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LATCH,
    DONE
  } state_t;

  state_t           r_state;
  logic [31:0]      r_cnt;
  logic [BW-1:0]    r_bit;
  logic [WIDTH-1:0] r_shreg;
  logic             r_lsb_first;
  logic             r_sclk;
  logic             r_sdata;
  logic             r_latch;
  logic             r_busy;
  logic             r_done;

  logic             w_tick;
  logic             w_last;
  logic [WIDTH-1:0] w_shreg_next;
  logic             w_sdata_next;

  assign w_tick = (r_cnt == 32'(DIVVAL));
  assign w_last = (r_bit == BW'(WIDTH - 1));

  // The word is shifted toward the output end so the next bit is always at a fixed position.
  always_comb begin
    w_shreg_next = r_lsb_first ? (r_shreg >> 1) : (r_shreg << 1);
    w_sdata_next = r_lsb_first ? w_shreg_next[0] : w_shreg_next[WIDTH-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shreg     <= '0;
      r_lsb_first <= 1'b0;
      r_sclk      <= 1'b0;
      r_sdata     <= 1'b0;
      r_latch     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_cnt <= (r_state == IDLE || r_state == DONE || w_tick) ? '0 : r_cnt + 32'd1;

      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_shreg     <= bus.data_in;
            r_lsb_first <= bus.lsb_first;
            r_bit       <= '0;
            r_busy      <= 1'b1;
            r_sdata     <= bus.lsb_first ? bus.data_in[0] : bus.data_in[WIDTH-1];
            r_state     <= SETUP;
          end
        end

        SETUP: begin
          if (w_tick) begin
            r_sclk  <= 1'b1;
            r_state <= HIGH;
          end
        end

        HIGH: begin
          if (w_tick) begin
            r_sclk <= 1'b0;
            if (!w_last) begin
              r_bit   <= r_bit + BW'(1);
              r_shreg <= w_shreg_next;
              r_sdata <= w_sdata_next;
              r_state <= SETUP;
            end else begin
              r_sdata <= 1'b0;
              r_latch <= 1'b1;
              r_state <= LATCH;
            end
          end
        end

        LATCH: begin
          if (w_tick) begin
            r_latch <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sclk  = r_sclk;
  assign bus.sdata = r_sdata;
  assign bus.latch = r_latch;
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule

// File: tb/tb_shift_out_ctrl.sv
// Scoreboard bench for shift_out_ctrl: three instances (DIVVAL 3, 0, 1) share one clock;
// stimulus queues expected bits/widths, a per-instance monitor pops and compares.
module tb_shift_out_ctrl;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic       rst_v   [3];
  logic       start_v [3];
  logic [7:0] din_v   [3];
  logic       lsb_v   [3];
  logic [4:0] w_outs  [3];   // {sclk, sdata, latch, busy, done}

  bit exp_bit_q   [3][$];
  int exp_busy_q  [3][$];
  int exp_latch_q [3][$];
  int exp_gap_q   [3][$];
  int exp_done_n  [3];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int D = (gi == 0) ? 3 : ((gi == 1) ? 0 : 1);

    shift_out_ctrl_if #(.WIDTH(8)) bus ();

    assign bus.start     = start_v[gi];
    assign bus.data_in   = din_v[gi];
    assign bus.lsb_first = lsb_v[gi];

    shift_out_ctrl #(.WIDTH(8), .DIVVAL(D)) u_dut (
      .clk_in (clk_in),
      .reset  (rst_v[gi]),
      .bus    (bus.slave)
    );

    assign w_outs[gi] = {bus.sclk, bus.sdata, bus.latch, bus.busy, bus.done};

    logic p_sclk = 1'b0, p_sdata = 1'b0, p_latch = 1'b0, p_busy = 1'b0, p_done = 1'b0;
    int   n_high = 0, n_latch = 0, n_busy = 0, n_done = 0, n_gap = 0;
    bit   seen_fall = 1'b0;

    always @(negedge clk_in) begin
      if (rst_v[gi]) begin
        {p_sclk, p_sdata, p_latch, p_busy, p_done} = 5'b0;
        n_high = 0; n_latch = 0; n_busy = 0; n_done = 0; n_gap = 0;
        seen_fall = 1'b0;
      end else begin
        if (bus.sclk && !p_sclk) begin
          check("sclk rise expected", int'(exp_bit_q[gi].size() > 0), 1);
          if (exp_bit_q[gi].size() > 0) begin
            bit e;
            e = exp_bit_q[gi].pop_front();
            check("sdata during setup", p_sdata, e);
            check("sdata at sclk rise", bus.sdata, e);
          end
        end
        if (bus.sclk) n_high++;
        else if (p_sclk) begin
          check("sclk high width", n_high, D + 1);
          n_high = 0;
        end

        if (bus.latch) n_latch++;
        else if (p_latch) begin
          check("latch expected", int'(exp_latch_q[gi].size() > 0), 1);
          if (exp_latch_q[gi].size() > 0) check("latch width", n_latch, exp_latch_q[gi].pop_front());
          n_latch = 0;
        end

        if (bus.busy && !p_busy) begin
          if (seen_fall && exp_gap_q[gi].size() > 0)
            check("busy gap", n_gap, exp_gap_q[gi].pop_front());
          seen_fall = 1'b0;
        end
        if (bus.busy) n_busy++;
        else begin
          if (p_busy) begin
            check("busy end expected", int'(exp_busy_q[gi].size() > 0), 1);
            if (exp_busy_q[gi].size() > 0) check("busy width", n_busy, exp_busy_q[gi].pop_front());
            n_busy = 0;
            seen_fall = 1'b1;
            n_gap = 0;
          end
          if (seen_fall) n_gap++;
        end

        if (bus.done && !p_done) begin
          check("done expected", int'(exp_done_n[gi] > 0), 1);
          if (exp_done_n[gi] > 0) exp_done_n[gi]--;
          check("busy low at done", bus.busy, 0);
        end
        if (bus.done) n_done++;
        else if (p_done) begin
          check("done width", n_done, 1);
          n_done = 0;
        end

        {p_sclk, p_sdata, p_latch, p_busy, p_done} =
          {bus.sclk, bus.sdata, bus.latch, bus.busy, bus.done};
      end
    end
  end

  // serial is the hand-computed bit sequence in time order, first bit in [7].
  task automatic send(input int d, input logic [7:0] data, input bit lsb,
                      input logic [7:0] serial, input int busy_len, input int latch_len,
                      input int poke_at, input int wait_cycles);
    for (int k = 7; k >= 0; k--) exp_bit_q[d].push_back(serial[k]);
    exp_busy_q[d].push_back(busy_len);
    exp_latch_q[d].push_back(latch_len);
    exp_done_n[d]++;
    @(posedge clk_in); #1;
    start_v[d] = 1'b1; din_v[d] = data; lsb_v[d] = lsb;
    @(posedge clk_in); #1;
    start_v[d] = 1'b0; din_v[d] = ~data; lsb_v[d] = ~lsb;
    if (poke_at > 0) begin
      repeat (poke_at) @(posedge clk_in);
      #1 start_v[d] = 1'b1; din_v[d] = 8'hFF; lsb_v[d] = 1'b1;
      @(posedge clk_in);
      #1 start_v[d] = 1'b0;
    end
    repeat (wait_cycles) @(posedge clk_in);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_v[d] = 1'b1; start_v[d] = 1'b0; din_v[d] = 8'h00; lsb_v[d] = 1'b0;
      exp_done_n[d] = 0;
    end
    start_v[0] = 1'b1; din_v[0] = 8'hFF;
    repeat (2) @(posedge clk_in);
    #1;
    for (int d = 0; d < 3; d++) check("outputs in reset", w_outs[d], 0);
    start_v[0] = 1'b0;
    for (int d = 0; d < 3; d++) rst_v[d] = 1'b0;
    repeat (2) @(posedge clk_in);

    // DIVVAL=3: busy 68, latch 4
    send(0, 8'h0F, 1'b0, 8'b0000_1111, 68, 4, 0, 75);
    send(0, 8'h0F, 1'b1, 8'b1111_0000, 68, 4, 0, 75);
    send(0, 8'h00, 1'b0, 8'b0000_0000, 68, 4, 17, 60);

    // Abort during bit 3 of 0x55 (MSB first): only bits 0,1,0 get clocked out.
    exp_bit_q[0].push_back(1'b0);
    exp_bit_q[0].push_back(1'b1);
    exp_bit_q[0].push_back(1'b0);
    @(posedge clk_in); #1;
    start_v[0] = 1'b1; din_v[0] = 8'h55; lsb_v[0] = 1'b0;
    @(posedge clk_in); #1;
    start_v[0] = 1'b0;
    repeat (25) @(posedge clk_in);
    #2 rst_v[0] = 1'b1;
    #1;
    check("abort sclk",  w_outs[0][4], 0);
    check("abort sdata", w_outs[0][3], 0);
    check("abort latch", w_outs[0][2], 0);
    check("abort busy",  w_outs[0][1], 0);
    check("abort done",  w_outs[0][0], 0);
    repeat (3) @(posedge clk_in);
    #2 rst_v[0] = 1'b0;
    repeat (80) @(posedge clk_in);

    send(0, 8'hA5, 1'b0, 8'b1010_0101, 68, 4, 0, 75);
    send(0, 8'h12, 1'b1, 8'b0100_1000, 68, 4, 0, 75);

    // DIVVAL=0: busy 17, latch 1, sclk toggles every cycle
    send(1, 8'hA5, 1'b0, 8'b1010_0101, 17, 1, 0, 25);
    send(1, 8'h12, 1'b1, 8'b0100_1000, 17, 1, 0, 25);

    // DIVVAL=1, start held: three back-to-back transfers with 2-cycle gaps
    for (int t = 0; t < 3; t++) begin
      for (int k = 0; k < 8; k++) exp_bit_q[2].push_back(k >= 4);
      exp_busy_q[2].push_back(34);
      exp_latch_q[2].push_back(2);
      exp_done_n[2]++;
    end
    exp_gap_q[2].push_back(2);
    exp_gap_q[2].push_back(2);
    @(posedge clk_in); #1;
    start_v[2] = 1'b1; din_v[2] = 8'h0F; lsb_v[2] = 1'b0;
    @(posedge clk_in);
    repeat (80) @(posedge clk_in);
    #1 start_v[2] = 1'b0;
    repeat (40) @(posedge clk_in);

    for (int d = 0; d < 3; d++) begin
      check("bits left unseen",     exp_bit_q[d].size(),   0);
      check("busy windows unseen",  exp_busy_q[d].size(),  0);
      check("latch pulses unseen",  exp_latch_q[d].size(), 0);
      check("done pulses unseen",   exp_done_n[d],         0);
      check("busy gaps unseen",     exp_gap_q[d].size(),   0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_out_ctrl.md
SHIFT_OUT_CTRL -- requirements
Module: shift_out_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of bits per transfer; legal values are 2 to 32.
REQ-002 The block SHALL have parameter DIVVAL, default 10, meaning the terminal count of the phase counter; each sclk phase lasts DIVVAL+1 clk_in cycles; legal values are 0 or greater.
REQ-003 The block SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: transfer request, sampled only in IDLE.
REQ-006 The block SHALL have port data_in, input, WIDTH bits: parallel word, captured when start is accepted.
REQ-007 The block SHALL have port lsb_first, input, 1 bit: bit order select, captured when start is accepted (1 = bit 0 first).
REQ-008 The block SHALL have port sclk, output, 1 bit: serial shift clock.
REQ-009 The block SHALL have port sdata, output, 1 bit: serial data.
REQ-010 The block SHALL have port latch, output, 1 bit: storage-register latch strobe.
REQ-011 The block SHALL have port busy, output, 1 bit: transfer in progress.
REQ-012 The block SHALL have port done, output, 1 bit: single-cycle completion pulse.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 The FSM SHALL have states IDLE, SETUP, HIGH, LATCH and DONE.
REQ-015 A 32-bit phase counter SHALL count 0..DIVVAL; tick = (counter == DIVVAL); on tick the counter returns to 0; the counter is held at 0 in IDLE and DONE.
REQ-016 In IDLE with start=1 at an edge, that edge SHALL capture data_in and lsb_first, clear the bit counter, set busy=1, drive sdata with the first bit (data_in[WIDTH-1], or data_in[0] if lsb_first=1), and enter SETUP.
REQ-017 In SETUP, sclk SHALL be 0 and sdata stable; on tick, sclk SHALL go to 1 and the FSM SHALL enter HIGH.
REQ-018 In HIGH on tick, sclk SHALL go to 0; if bit count < WIDTH-1, the bit counter SHALL increment, sdata SHALL present the next bit, and the FSM SHALL enter SETUP; otherwise sdata SHALL go to 0, latch SHALL go to 1, and the FSM SHALL enter LATCH.
REQ-019 In LATCH on tick, latch SHALL go to 0, busy SHALL go to 0, done SHALL go to 1, and the FSM SHALL enter DONE.
REQ-020 DONE SHALL last exactly one cycle, then done SHALL go to 0 and the FSM SHALL enter IDLE.
REQ-021 Busy SHALL be high for exactly (2*WIDTH+1)*(DIVVAL+1) cycles per transfer.
REQ-022 start, data_in and lsb_first SHALL be ignored outside IDLE; a transfer in progress SHALL NOT be altered by them.
REQ-023 With start held high continuously, successive transfers SHALL be separated by exactly 2 cycles of busy=0 (DONE, then IDLE).
REQ-024 DIVVAL=0 SHALL give a tick every cycle, so sclk toggles every clk_in cycle during the shift.
REQ-025 sdata SHALL change only on edges where sclk goes low or at start acceptance; it SHALL never change on the edge where sclk goes high.

Reset
REQ-026 reset=1 SHALL immediately, regardless of clk_in, force state IDLE, counters 0, shift register 0, and sclk, sdata, latch, busy and done all 0.
REQ-027 Reset asserted mid-transfer SHALL abort the transfer with no latch pulse and no done pulse.
REQ-028 After reset is released, the first start SHALL be accepted normally.

Verification
REQ-029 WIDTH=8, DIVVAL=3, data_in=0x0F, lsb_first=0, 1-cycle start -> sdata at the 8 sclk rising edges is 0,0,0,0,1,1,1,1; each sclk high phase is 4 cycles; latch is high 4 cycles; busy is high 68 cycles; done pulses 1 cycle, 68 cycles after the start edge.
REQ-030 Same as REQ-029 with lsb_first=1 -> sdata at the sclk rising edges is 1,1,1,1,0,0,0,0.
REQ-031 start=1 with data_in=0xFF pulsed during bit 2 of a 0x00 transfer -> all 8 sampled bits are 0; there is a single done pulse; busy timing is unchanged.
REQ-032 reset asserted asynchronously mid-cycle during bit 3 -> all outputs are 0 before the next clk_in edge; there is no latch or done pulse; a later start with 0xA5 shifts 1,0,1,0,0,1,0,1.
REQ-033 DIVVAL=0, WIDTH=8 -> sclk alternates every cycle; busy is high 17 cycles; latch is high 1 cycle.
REQ-034 start held high for 3 transfers, DIVVAL=1 -> three busy windows of 34 cycles each, separated by 2 low cycles; 3 done pulses.
